// File: rtl/sort_pkg.sv
// sort_pkg: shared widths, drain FSM states and a constant log2 helper for the sort core
package sort_pkg;
  localparam int DATA_W = 32;
  localparam int COUNT_W = 11;
  localparam int MAX_ELEMS = 1024;
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sort_drain_fifo.sv
// sort_drain_fifo: synchronous FIFO with wrap-bit pointers and a combinational head read
module sort_drain_fifo import sort_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [clog2(DEPTH):0]    count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign count = wp - rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // Head reads as zero when empty so nothing stale leaks onto the stream
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clock)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/sort_drain.sv
// sort_drain: pulls the sorted array out of the core, streams it with a last flag,
// and flags any unsigned descent in the stream
module sort_drain import sort_pkg::*; #(
  parameter int DATA_W = sort_pkg::DATA_W,
  parameter int COUNT_W = sort_pkg::COUNT_W,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               drain_start,
  input  logic [COUNT_W-1:0] elem_count,
  output logic               rd_en,
  input  logic [DATA_W-1:0]  sorted_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic               busy,
  output logic               drain_done,
  output logic               order_err
);
  localparam int IW = clog2(FIFO_DEPTH) + 1;
  state_t state, nxt;
  logic [COUNT_W-1:0] issue_left, accept_left;
  logic [IW-1:0] inflight, fifo_count;
  logic [RD_LAT-1:0] rd_pipe;
  logic [DATA_W-1:0] prev_word;
  logic prev_valid, push, pop, empty, full, start, last_acc;
  assign start = drain_start && state == IDLE;
  assign push = rd_pipe[RD_LAT-1];
  assign m_valid = !empty;
  assign pop = m_valid && m_ready;
  assign m_last = m_valid && accept_left == COUNT_W'(1);
  assign last_acc = pop && accept_left == COUNT_W'(1);
  assign busy = state != IDLE;
  sort_drain_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .wdata(sorted_data),
    .rdata(m_data), .count(fifo_count), .empty(empty), .full(full)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // Credit rule: words buffered plus words in flight never exceed the FIFO depth
  always_comb begin
    rd_en = state == ISSUE && issue_left != '0 && !full && (fifo_count + inflight) < IW'(FIFO_DEPTH);
    nxt = (start && elem_count != '0) ? ISSUE :
          (state == ISSUE && rd_en && issue_left == COUNT_W'(1)) ? FLUSH :
          (state == FLUSH && last_acc) ? IDLE : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rd_pipe <= '0;
      inflight <= '0;
      issue_left <= '0;
      accept_left <= '0;
      prev_word <= '0;
      prev_valid <= 1'b0;
      order_err <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_en);
      inflight <= inflight + IW'(rd_en) - IW'(push);
      drain_done <= (start && elem_count == '0) || (state == FLUSH && last_acc);
      if (start) begin
        issue_left <= elem_count;
        accept_left <= elem_count;
        order_err <= 1'b0;
        prev_valid <= 1'b0;
      end else begin
        if (rd_en) issue_left <= issue_left - COUNT_W'(1);
        if (pop) accept_left <= accept_left - COUNT_W'(1);
        if (push) begin
          order_err <= order_err || (prev_valid && sorted_data < prev_word);
          prev_word <= sorted_data;
          prev_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_sort_drain.sv
// tb_sort_drain: randomized scoreboard bench for sort_drain with a core RAM model
module tb_sort_drain;
  typedef struct {logic [31:0] d; logic l;} beat_t;
  logic clock = 0, reset = 0, drain_start = 0, m_ready = 0;
  logic [10:0] elem_count = '0;
  logic [31:0] sorted_data = '0;
  logic rd_en, m_valid, m_last, busy, drain_done, order_err;
  logic [31:0] m_data;
  int total = 0, bad = 0, cyc = 0, ready_mode = 0;
  int rd_cnt = 0, acc_cnt = 0, last_acc_cyc = -1, start_cyc = 0, idx = 0;
  logic [31:0] mem [1024];
  logic [31:0] prev_w = '0;
  logic have_prev = 0, exp_oe = 0, exp_err = 0;
  beat_t exp_q[$];

  sort_drain dut (
    .clock(clock), .reset(reset), .drain_start(drain_start), .elem_count(elem_count),
    .rd_en(rd_en), .sorted_data(sorted_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .drain_done(drain_done), .order_err(order_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Core RAM model: word appears one cycle after each rd_en; order model updates when it lands
  initial begin
    logic r, pend;
    logic [31:0] pw;
    pend = 0;
    pw = '0;
    forever begin
      @(negedge clock);
      r = rd_en;
      if (r) rd_cnt++;
      @(posedge clock);
      #1;
      if (pend) begin
        if (have_prev && pw < prev_w) exp_oe = 1;
        prev_w = pw;
        have_prev = 1;
        pend = 0;
      end
      if (r) begin
        sorted_data = mem[idx % 1024];
        pw = sorted_data;
        pend = 1;
        idx++;
      end else sorted_data = $urandom;
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor: every visible beat must match the scoreboard head
  always @(negedge clock) if (reset) begin
    beat_t e;
    chk("order_err", order_err, exp_oe);
    if (m_valid) begin
      if (exp_q.size() == 0) chk("extra_beat", m_valid, 0);
      else begin
        chk("m_data", m_data, exp_q[0].d);
        chk("m_last", m_last, exp_q[0].l);
        if (m_ready) begin
          e = exp_q.pop_front();
          acc_cnt++;
          if (e.l) last_acc_cyc = cyc;
        end
      end
    end else if (m_last) chk("m_last_idle", m_last, 0);
  end

  task automatic begin_drain(input int n);
    exp_err = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{d: mem[i], l: i == n - 1});
      if (i > 0 && mem[i] < mem[i-1]) exp_err = 1;
    end
    @(posedge clock);
    #1;
    idx = 0;
    rd_cnt = 0;
    acc_cnt = 0;
    elem_count = 11'(n);
    drain_start = 1;
    start_cyc = cyc;
    @(posedge clock);
    #1;
    drain_start = 0;
    exp_oe = 0;
    have_prev = 0;
  endtask

  task automatic finish_drain(input int n);
    int dc;
    logic busy_seen;
    dc = -1;
    busy_seen = 0;
    for (int i = 0; i < 20 * n + 50; i++) begin
      @(negedge clock);
      if (busy) busy_seen = 1;
      if (drain_done) begin
        dc = cyc;
        break;
      end
    end
    chk("done_seen", dc >= 0, 1);
    chk("done_time", 64'(dc), 64'(n == 0 ? start_cyc + 1 : last_acc_cyc + 1));
    chk("busy_seen", busy_seen, n != 0);
    chk("order_err_end", order_err, exp_err);
    @(negedge clock);
    chk("done_pulse", drain_done, 0);
    chk("busy_idle", busy, 0);
    chk("order_err_hold", order_err, exp_err);
    chk("rd_cnt", rd_cnt, n);
    chk("acc_cnt", acc_cnt, n);
    chk("q_left", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_oerr", order_err, 0);
    chk("rst_m_data", m_data, 0);
    @(posedge clock);
    #2 reset = 1;
    // 1: five ascending words, consumer always ready
    for (int i = 0; i < 5; i++) mem[i] = 32'(i + 1);
    begin_drain(5);
    finish_drain(5);
    // 2: empty drain
    begin_drain(0);
    finish_drain(0);
    // 3: backpressure stalls issue at FIFO depth
    for (int i = 0; i < 8; i++) mem[i] = 32'(100 + 3 * i);
    ready_mode = 2;
    begin_drain(8);
    repeat (20) @(negedge clock);
    chk("bp_rd_cnt", rd_cnt, 4);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, mem[0]);
    ready_mode = 0;
    finish_drain(8);
    // 4: descent flags order_err, which sticks
    mem[0] = 3; mem[1] = 7; mem[2] = 7; mem[3] = 2; mem[4] = 9;
    begin_drain(5);
    finish_drain(5);
    // 5: async reset mid-drain, then a clean short drain
    for (int i = 0; i < 10; i++) mem[i] = 32'(i * 5);
    begin_drain(10);
    chk("oerr_cleared", order_err, 0);
    for (int i = 0; i < 100 && acc_cnt < 3; i++) @(negedge clock);
    chk("mid_acc", acc_cnt >= 3, 1);
    #2 reset = 0;
    #1;
    chk("ar_rd_en", rd_en, 0);
    chk("ar_m_valid", m_valid, 0);
    chk("ar_m_last", m_last, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", drain_done, 0);
    chk("ar_m_data", m_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #3 reset = 1;
    exp_oe = 0;
    have_prev = 0;
    mem[0] = 32'hFFFF_FFF0; mem[1] = 32'hFFFF_FFFF;
    begin_drain(2);
    finish_drain(2);
    // 6: long random-ascending drain with random backpressure
    mem[0] = $urandom_range(0, 100);
    for (int i = 1; i < 1024; i++) mem[i] = mem[i-1] + $urandom_range(0, 3);
    ready_mode = 1;
    begin_drain(1024);
    finish_drain(1024);
    ready_mode = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
